uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals shared by uart_tx_arbiter and its users
// master is the arbiter side; slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic [IDW-1:0]    grant_id;
  logic              active;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output ack, err, tx_start, tx_data, grant_id, active
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  ack, err, tx_start, tx_data, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NREQ requesters, with frame timeout
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int              IDW      = $clog2(NREQ);
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(NREQ - 1);
  localparam logic [7:0]      TMO      = 8'(TIMEOUT);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state, state_d;
  logic [7:0]      timer, timer_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic            active_q, active_d;
  logic [IDW-1:0]  scan_base, winner, cand;
  logic            found;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Scanning from the top index makes requester 0 the first candidate every time.
  assign scan_base = LAST_IDX;
`else
  logic [IDW-1:0] last_owner, owner_d;
  assign scan_base = last_owner;
`endif

  // Walk the request vector starting one past scan_base, wrapping at NREQ-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = scan_base;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDW'(1);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    ack_d   = '0;
    err_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    owner_d = last_owner;
`endif
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_d = winner;
          data_d  = bus.req_data[{winner, 3'b000} +: 8];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.tx_busy) begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // tx_done takes precedence when it lands on the timeout cycle.
        if (bus.tx_done) begin
          ack_d   = ONE << grant_q;
          state_d = IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
          owner_d = grant_q;
`endif
        end else if (timer == TMO) begin
          err_d   = ONE << grant_q;
          state_d = IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
          owner_d = grant_q;
`endif
        end else begin
          timer_d = timer + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      active_q <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_owner <= LAST_IDX;
`endif
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      start_q  <= start_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      active_q <= active_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_owner <= owner_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with NREQ=4, TIMEOUT=31
// Expected order follows UART_ARB_FIXED_PRIO_EN when defined.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();
  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(31)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [1:0] id; logic [7:0] data; } grant_t;
  typedef struct packed { logic [1:0] id; logic is_err; } rel_t;

  grant_t     exp_g[$];
  rel_t       exp_r[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0, start_cyc = 0, rel_cyc = 0, n_start = 0, n_rel = 0;
  int         model_last = 3;
  logic [1:0] cur_id = 2'd0;
  bit         auto_drop = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] r, input int last);
    logic [1:0] w;
    w = 2'd0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (r[2'(k)]) w = 2'(k);
`else
    for (int k = 4; k >= 1; k--) begin
      logic [1:0] c;
      c = 2'(last + k);
      if (r[c]) w = c;
    end
`endif
    return w;
  endfunction

  task automatic push_grant(input logic [3:0] r, input int last, output logic [1:0] w);
    grant_t g;
    w      = pick(r, last);
    g.id   = w;
    g.data = bus.req_data[{w, 3'b000} +: 8];
    exp_g.push_back(g);
  endtask

  // One clock; samples 1 time unit after the edge and scores tx_start / release events.
  task automatic step();
    grant_t     g;
    rel_t       e;
    logic [3:0] oh;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tx_start) begin
      n_start++;
      start_cyc = cyc;
      chk("grant_pending", 32'(exp_g.size() != 0), 32'(1));
      if (exp_g.size() != 0) begin
        g      = exp_g.pop_front();
        cur_id = g.id;
        chk("grant_id", 32'(bus.grant_id), 32'(g.id));
        chk("tx_data", 32'(bus.tx_data), 32'(g.data));
      end
    end
    if ((bus.ack | bus.err) != 4'b0) begin
      n_rel++;
      rel_cyc = cyc;
      chk("release_pending", 32'(exp_r.size() != 0), 32'(1));
      if (exp_r.size() != 0) begin
        e  = exp_r.pop_front();
        oh = 4'b0001 << e.id;
        chk("ack_err", 32'({bus.err, bus.ack}), e.is_err ? 32'({oh, 4'b0000}) : 32'({4'b0000, oh}));
        model_last = int'(e.id);
      end
      if (auto_drop) bus.req = bus.req & ~(bus.ack | bus.err);
    end
  endtask

  task automatic wait_start(input int bound);
    int s0;
    s0 = n_start;
    for (int b = 0; b < bound && n_start == s0; b++) step();
    chk("tx_start_seen", 32'(n_start != s0), 32'(1));
  endtask

  task automatic wait_rel(input int r0, input int bound);
    for (int b = 0; b < bound && n_rel == r0; b++) step();
    chk("release_seen", 32'(n_rel != r0), 32'(1));
  endtask

  task automatic serve(input int dly, input bit timeout);
    rel_t e;
    int   r0;
    e.id     = cur_id;
    e.is_err = timeout;
    exp_r.push_back(e);
    r0 = n_rel;
    if (timeout) begin
      wait_rel(r0, 40);
    end else begin
      repeat (dly) step();
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      wait_rel(r0, 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] w;
    int l, t, s0, r0;
    rst          = 1'b1;
    bus.req      = 4'b0000;
    bus.req_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    repeat (3) step();
    chk("rst_active", 32'(bus.active), 32'(0));
    chk("rst_outputs", 32'({bus.ack, bus.err, bus.tx_start, bus.grant_id}), 32'(0));
    chk("rst_tx_data", 32'(bus.tx_data), 32'(0));
    rst = 1'b0;
    step();

    // Single request, first-transaction latency, req_data changed after grant
    bus.req = 4'b0100;
    push_grant(bus.req, model_last, w);
    s0 = n_start;
    step();
    chk("latency_active", 32'(bus.active), 32'(1));
    chk("latency_no_early_start", 32'(bus.tx_start), 32'(0));
    bus.req_data[23:16] = 8'hFF;
    step();
    chk("latency_start", 32'(n_start - s0), 32'(1));
    serve(12, 1'b0);
    chk("ack_latency", 32'(rel_cyc - start_cyc), 32'(13));
    chk("tx_data_held", 32'(bus.tx_data), 32'hA5);
    repeat (4) step();
    chk("single_start_count", 32'(n_start), 32'(1));
    chk("single_ack_count", 32'(n_rel), 32'(1));
    chk("idle_after_ack", 32'(bus.active), 32'(0));
    bus.req_data[23:16] = 8'hA5;

    // tx_done while idle
    r0 = n_rel;
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    repeat (2) step();
    chk("done_idle_ignored", 32'(n_rel - r0), 32'(0));
    chk("done_idle_inactive", 32'(bus.active), 32'(0));

    // Reset in WAIT_DONE drops the grant silently
    bus.req = 4'b1000;
    push_grant(bus.req, model_last, w);
    wait_start(8);
    repeat (5) step();
    r0  = n_rel;
    rst = 1'b1;
    #1;
    chk("rst_mid_active", 32'(bus.active), 32'(0));
    chk("rst_mid_outputs", 32'({bus.ack, bus.err, bus.tx_start, bus.grant_id}), 32'(0));
    chk("rst_mid_tx_data", 32'(bus.tx_data), 32'(0));
    repeat (3) step();
    chk("rst_mid_no_release", 32'(n_rel - r0), 32'(0));
    model_last = 3;

    // Four frames with all requests held; first grant after reset goes to 0
    auto_drop = 1'b0;
    bus.req   = 4'b1111;
    l = model_last;
    for (int f = 0; f < 4; f++) begin
      push_grant(4'b1111, l, w);
      l = int'(w);
    end
    rst = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_start(8);
      serve(f + 1, 1'b0);
    end
    bus.req   = 4'b0000;
    auto_drop = 1'b1;
    step();

    // Transmitter busy stall, with a stray tx_done during ISSUE
    bus.tx_busy = 1'b1;
    bus.req     = 4'b0010;
    push_grant(bus.req, model_last, w);
    s0 = n_start;
    r0 = n_rel;
    repeat (2) step();
    chk("stall_active", 32'(bus.active), 32'(1));
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    repeat (17) step();
    chk("stall_no_start", 32'(n_start - s0), 32'(0));
    chk("stall_done_ignored", 32'(n_rel - r0), 32'(0));
    bus.tx_busy = 1'b0;
    t = cyc;
    step();
    chk("stall_start_after_busy", 32'(n_start - s0), 32'(1));
    chk("stall_start_cycle", 32'(start_cyc - t), 32'(1));
    serve(4, 1'b0);

    // Timeout with tx_done never returned
    bus.req = 4'b0001;
    push_grant(bus.req, model_last, w);
    wait_start(8);
    serve(0, 1'b1);
    chk("timeout_latency", 32'(rel_cyc - start_cyc), 32'(32));

    // tx_done on the very cycle the timer hits TIMEOUT
    bus.req = 4'b0100;
    push_grant(bus.req, model_last, w);
    wait_start(8);
    serve(31, 1'b0);
    chk("collision_latency", 32'(rel_cyc - start_cyc), 32'(32));

    // Two held requesters after owner 2
    auto_drop = 1'b0;
    bus.req   = 4'b0101;
    l = model_last;
    for (int f = 0; f < 2; f++) begin
      push_grant(4'b0101, l, w);
      l = int'(w);
    end
    for (int f = 0; f < 2; f++) begin
      wait_start(8);
      serve(2, 1'b0);
    end
    bus.req   = 4'b0000;
    auto_drop = 1'b1;
    repeat (3) step();
    chk("final_idle", 32'(bus.active), 32'(0));
    chk("grant_queue_drained", 32'(exp_g.size()), 32'(0));
    chk("release_queue_drained", 32'(exp_r.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
